// File: rtl/cond_unit.sv
// Flag-holding condition evaluator with masked ALU updates, NUM_PORTS registered
// condition queries and a DEPTH-entry LIFO flag checkpoint stack.
// Optional FLAG_BYPASS_EN: queries see the next flag value instead of the register.

module cond_lane (
  input  logic [3:0] flags_i,
  input  logic [3:0] sel_i,
  output logic       pass_o
);
  logic c, n, v, z;
  assign {c, n, v, z} = flags_i;

  always_comb begin
    pass_o = 1'b0;
    case (sel_i)
      4'd0:  pass_o = z;
      4'd1:  pass_o = ~z;
      4'd2:  pass_o = c;
      4'd3:  pass_o = ~c;
      4'd4:  pass_o = n;
      4'd5:  pass_o = ~n;
      4'd6:  pass_o = v;
      4'd7:  pass_o = ~v;
      4'd8:  pass_o = c & ~z;
      4'd9:  pass_o = ~c | z;
      4'd10: pass_o = ~(n ^ v);
      4'd11: pass_o = n ^ v;
      4'd12: pass_o = ~z & ~(n ^ v);
      4'd13: pass_o = z | (n ^ v);
      default: pass_o = 1'b1;
    endcase
  end
endmodule

module cond_unit #(
  parameter int          NUM_PORTS   = 2,
  parameter int          DEPTH       = 4,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flag_we,
  input  logic [3:0]             flag_in,
  input  logic [3:0]             flag_mask,
  input  logic [NUM_PORTS-1:0]   cond_valid,
  input  logic [4*NUM_PORTS-1:0] cond_sel,
  output logic [NUM_PORTS-1:0]   cond_pass,
  output logic [NUM_PORTS-1:0]   pass_valid,
  output logic [3:0]             flags_out,
  input  logic                   ckpt_push,
  input  logic                   ckpt_pop,
  output logic                   ckpt_full,
  output logic                   ckpt_empty,
  output logic                   ckpt_err
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0]           flags_q, flags_d, merged, eval_flags, top_entry;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           stk_q [DEPTH];
  logic                 push_ok, pop_ok, err_d, err_q;
  logic [NUM_PORTS-1:0] lane_pass, pass_q, vld_q;

  assign ckpt_full  = (cnt_q == CW'(DEPTH));
  assign ckpt_empty = (cnt_q == '0);
  assign push_ok    = ckpt_push & ~ckpt_pop & ~ckpt_full;
  assign pop_ok     = ckpt_pop & ~ckpt_push & ~ckpt_empty;
  assign err_d      = (ckpt_push & ckpt_pop) | (ckpt_push & ckpt_full) | (ckpt_pop & ckpt_empty);
  assign merged     = flag_we ? ((flags_q & ~flag_mask) | (flag_in & flag_mask)) : flags_q;

`ifdef FLAG_BYPASS_EN
  // A legal pop overrides the update, so queries then see the pre-pop register.
  assign eval_flags = pop_ok ? flags_q : merged;
`else
  assign eval_flags = flags_q;
`endif

  always_comb begin
    top_entry = '0;
    for (int i = 0; i < DEPTH; i++)
      if (cnt_q == CW'(i + 1)) top_entry = stk_q[i];
  end

  always_comb begin
    flags_d = pop_ok ? top_entry : merged;
    cnt_d   = cnt_q;
    if (push_ok)     cnt_d = cnt_q + 1'b1;
    else if (pop_ok) cnt_d = cnt_q - 1'b1;
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
    cond_lane u_lane (
      .flags_i (eval_flags),
      .sel_i   (cond_sel[4*g +: 4]),
      .pass_o  (lane_pass[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= RESET_FLAGS;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      pass_q  <= '0;
      vld_q   <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= lane_pass & cond_valid;
      vld_q   <= cond_valid;
    end
  end

  // Stack storage needs no reset: entries above the count are never read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (push_ok && cnt_q == CW'(i)) stk_q[i] <= flags_q;
  end

  assign flags_out  = flags_q;
  assign cond_pass  = pass_q;
  assign pass_valid = vld_q;
  assign ckpt_err   = err_q;
endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit (NUM_PORTS=2, DEPTH=4): vector table through a scoreboard
// queue, then hand sequences for the checkpoint stack and asynchronous reset.

module tb_cond_unit;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       flag_we = 1'b0, ckpt_push = 1'b0, ckpt_pop = 1'b0;
  logic [3:0] flag_in = '0, flag_mask = '0, flags_out;
  logic [1:0] cond_valid = '0, cond_pass, pass_valid;
  logic [7:0] cond_sel = '0;
  logic       ckpt_full, ckpt_empty, ckpt_err;

  int ncmp = 0, nerr = 0;

  cond_unit #(.NUM_PORTS(2), .DEPTH(4), .RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_in(flag_in), .flag_mask(flag_mask),
    .cond_valid(cond_valid), .cond_sel(cond_sel), .cond_pass(cond_pass),
    .pass_valid(pass_valid), .flags_out(flags_out), .ckpt_push(ckpt_push),
    .ckpt_pop(ckpt_pop), .ckpt_full(ckpt_full), .ckpt_empty(ckpt_empty), .ckpt_err(ckpt_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [3:0] fin, mask;
    logic [1:0] vld;
    logic [7:0] sel;
    logic [1:0] ep, ev;
    logic [3:0] ef;
  } vec_t;

  typedef struct packed {
    logic [1:0] p, v;
    logic [3:0] f;
  } exp_t;

  vec_t tv [14];
  exp_t sbq [$];
  exp_t e;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle at the current negedge; outputs are stable at the next one.
  task automatic step(input logic we, input logic [3:0] fin, input logic [3:0] mask,
                      input logic push, input logic pop);
    flag_we = we; flag_in = fin; flag_mask = mask; ckpt_push = push; ckpt_pop = pop;
    @(negedge clk);
    flag_we = 1'b0; flag_in = '0; flag_mask = '0; ckpt_push = 1'b0; ckpt_pop = 1'b0;
  endtask

  initial begin
    //          we    fin    mask   vld    sel    ep     ev     ef
    tv[0]  = '{1'b1, 4'h1, 4'hF, 2'b00, 8'h00, 2'b00, 2'b00, 4'h1};
    tv[1]  = '{1'b0, 4'h0, 4'h0, 2'b11, 8'h10, 2'b01, 2'b11, 4'h1}; // EQ / NE
    tv[2]  = '{1'b1, 4'h4, 4'hF, 2'b00, 8'h00, 2'b00, 2'b00, 4'h4};
    tv[3]  = '{1'b1, 4'h6, 4'hF, 2'b11, 8'hBA, 2'b10, 2'b11, 4'h6}; // GE/LT on pre-update N=1,V=0
    tv[4]  = '{1'b0, 4'h0, 4'h0, 2'b11, 8'hBA, 2'b01, 2'b11, 4'h6}; // GE/LT with N=V=1
    tv[5]  = '{1'b0, 4'h0, 4'h0, 2'b11, 8'hDC, 2'b01, 2'b11, 4'h6}; // GT / LE
    tv[6]  = '{1'b1, 4'hF, 4'hF, 2'b00, 8'h00, 2'b00, 2'b00, 4'hF};
    tv[7]  = '{1'b1, 4'h0, 4'h5, 2'b00, 8'h00, 2'b00, 2'b00, 4'hA}; // masked clear of N,Z
    tv[8]  = '{1'b0, 4'h0, 4'h0, 2'b11, 8'h98, 2'b01, 2'b11, 4'hA}; // HI / LS
    tv[9]  = '{1'b0, 4'h0, 4'h0, 2'b11, 8'hFE, 2'b11, 2'b11, 4'hA}; // AL 14 / 15
    tv[10] = '{1'b0, 4'h0, 4'h0, 2'b01, 8'h62, 2'b01, 2'b01, 4'hA}; // CS, port1 idle
    tv[11] = '{1'b0, 4'h0, 4'h0, 2'b10, 8'h74, 2'b00, 2'b10, 4'hA}; // VC fails, port0 idle
    tv[12] = '{1'b0, 4'h0, 4'h0, 2'b11, 8'h35, 2'b01, 2'b11, 4'hA}; // PL / CC
    tv[13] = '{1'b0, 4'h5, 4'hF, 2'b11, 8'hFE, 2'b11, 2'b11, 4'hA}; // no strobe, flags hold

    #2;
    chk("rst_flags", {4'h0, flags_out}, 8'h00);
    chk("rst_pass", {6'h0, cond_pass}, 8'h00);
    chk("rst_valid", {6'h0, pass_valid}, 8'h00);
    chk("rst_empty_full_err", {5'h0, ckpt_empty, ckpt_full, ckpt_err}, 8'h04);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      flag_we = tv[i].we; flag_in = tv[i].fin; flag_mask = tv[i].mask;
      cond_valid = tv[i].vld; cond_sel = tv[i].sel;
      sbq.push_back('{tv[i].ep, tv[i].ev, tv[i].ef});
      @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("vec%0d_pass", i), {6'h0, cond_pass}, {6'h0, e.p});
      chk($sformatf("vec%0d_valid", i), {6'h0, pass_valid}, {6'h0, e.v});
      chk($sformatf("vec%0d_flags", i), {4'h0, flags_out}, {4'h0, e.f});
    end
    flag_we = 1'b0; cond_valid = '0; cond_sel = '0;

    // Fill the stack with 1,2,3,4 (each push saves the pre-update value).
    step(1'b1, 4'h1, 4'hF, 1'b0, 1'b0);
    for (int i = 2; i <= 5; i++) step(1'b1, 4'(i), 4'hF, 1'b1, 1'b0);
    chk("fill_full", {7'h0, ckpt_full}, 8'h01);
    chk("fill_flags", {4'h0, flags_out}, 8'h05);
    step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("push_full_err", {7'h0, ckpt_err}, 8'h01);
    chk("push_full_still_full", {7'h0, ckpt_full}, 8'h01);
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("err_one_cycle", {7'h0, ckpt_err}, 8'h00);
    for (int i = 4; i >= 1; i--) begin
      step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      chk($sformatf("pop_lifo_%0d", i), {4'h0, flags_out}, 8'(i));
    end
    chk("drain_empty", {7'h0, ckpt_empty}, 8'h01);
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("pop_empty_err", {7'h0, ckpt_err}, 8'h01);
    chk("pop_empty_flags", {4'h0, flags_out}, 8'h01);
    step(1'b1, 4'h7, 4'hF, 1'b0, 1'b1);
    chk("pop_empty_we_applies", {4'h0, flags_out}, 8'h07);
    step(1'b1, 4'h1, 4'hF, 1'b0, 1'b0);

    // Push alongside an update, then pop alongside an ignored update.
    step(1'b1, 4'hA, 4'hF, 1'b1, 1'b0);
    chk("push_we_flags", {4'h0, flags_out}, 8'h0A);
    step(1'b1, 4'h5, 4'hF, 1'b0, 1'b1);
    chk("pop_beats_we", {4'h0, flags_out}, 8'h01);
    chk("pop_we_empty", {7'h0, ckpt_empty}, 8'h01);
    step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    step(1'b1, 4'h3, 4'hF, 1'b1, 1'b1);
    chk("pushpop_err", {7'h0, ckpt_err}, 8'h01);
    chk("pushpop_we_applies", {4'h0, flags_out}, 8'h03);
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("pushpop_count_kept", {4'h0, flags_out}, 8'h01);
    chk("pushpop_then_empty", {7'h0, ckpt_empty}, 8'h01);

    // Asynchronous reset mid-query with two stacked entries.
    step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    cond_valid = 2'b11; cond_sel = 8'hFE;
    @(posedge clk); #2;
    chk("pre_reset_pass", {6'h0, cond_pass}, 8'h03);
    rst_n = 1'b0;
    #1;
    chk("async_flags", {4'h0, flags_out}, 8'h00);
    chk("async_pass", {6'h0, cond_pass}, 8'h00);
    chk("async_valid", {6'h0, pass_valid}, 8'h00);
    chk("async_empty", {7'h0, ckpt_empty}, 8'h01);
    @(negedge clk); rst_n = 1'b1; cond_valid = '0; cond_sel = '0;
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("stack_discarded_err", {7'h0, ckpt_err}, 8'h01);

`ifdef FLAG_BYPASS_EN
    cond_valid = 2'b01; cond_sel = 8'h00;
    step(1'b1, 4'h1, 4'hF, 1'b0, 1'b0);
    cond_valid = '0;
    chk("bypass_eq", {6'h0, cond_pass}, 8'h01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
Flag-holding condition evaluation unit for the ARMv4 datapath, and the parametrised successor of the combinational condition checker. It keeps the architectural flag register and accepts masked flag updates from the ALU. It evaluates NUM_PORTS independent condition fields per cycle with a registered result. It also provides a DEPTH-entry flag checkpoint stack, so flags can be saved and restored across flushes and exceptions.

Parameters:
NUM_PORTS, 2, number of independent condition query channels (1..8)
DEPTH, 4, checkpoint stack entries (1..16, any value)
RESET_FLAGS, 4'b0000, flag register value after reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flag_we  in  1  flag update strobe
flag_in  in  4  new flags {C,N,V,Z} (bit3=C, bit2=N, bit1=V, bit0=Z)
flag_mask  in  4  per-bit update enable, same bit order
cond_valid  in  NUM_PORTS  query valid, one bit per port
cond_sel  in  4*NUM_PORTS  condition code; port k uses bits [4k+3:4k]
cond_pass  out  NUM_PORTS  registered pass result per port
pass_valid  out  NUM_PORTS  registered copy of cond_valid
flags_out  out  4  current flag register
ckpt_push  in  1  save flag register onto stack
ckpt_pop  in  1  restore flag register from stack
ckpt_full  out  1  stack holds DEPTH entries
ckpt_empty  out  1  stack holds 0 entries
ckpt_err  out  1  one-cycle pulse on an illegal stack request

Behaviour:
- Reset (asynchronous, rst_n=0):
  - flags=RESET_FLAGS; stack count=0, so ckpt_empty=1 and ckpt_full=0.
  - cond_pass=0, pass_valid=0, ckpt_err=0.
  - Stack contents are don't-care.
  - Reset asserted mid-operation discards any in-flight result and the whole stack.
- Condition codes: 0 EQ=Z, 1 NE=~Z, 2 CS=C, 3 CC=~C, 4 MI=N, 5 PL=~N, 6 VS=V, 7 VC=~V, 8 HI=C&~Z, 9 LS=~C|Z, 10 GE=~(N^V), 11 LT=N^V, 12 GT=~Z&~(N^V), 13 LE=Z|(N^V), 14 AL=1, 15 AL=1.
- Evaluation timing:
  - Evaluation uses the flag register value before this cycle's update.
  - Results register at the clock edge: cond_pass[k] and pass_valid[k] appear 1 cycle after the query.
  - If cond_valid[k]=0, then cond_pass[k]=0 and pass_valid[k]=0 that cycle.
  - All ports are evaluated in parallel; there are no port interactions.
- Flag update: when flag_we=1, for each bit i with flag_mask[i]=1, flags[i]<=flag_in[i]; masked-off bits hold.
- Stack push (ckpt_push=1, ckpt_pop=0, not full):
  - The entry written is the pre-update flag value of that cycle.
  - count+1.
  - A flag_we in the same cycle still applies to the flag register.
- Stack pop (ckpt_pop=1, ckpt_push=0, not empty):
  - flags<=top entry and count-1.
  - Pop has priority: a flag_we in the same cycle is ignored entirely.
- Illegal stack requests (ckpt_err=1 next cycle in all three cases):
  - Push when full: dropped; stack unchanged.
  - Pop when empty: dropped; flags unchanged by stack; flag_we applies normally.
  - Push and pop together: both dropped; flag_we applies normally.
- Stack order is LIFO. The count register is $clog2(DEPTH+1) bits. ckpt_full and ckpt_empty are decoded from the registered count; there is no wrap-around.
- flags_out is the register output directly, with no combinational path from inputs.

Optional Feature:
FLAG_BYPASS_EN
- Defined: queries evaluate against the next flag value, i.e. the masked merge of flag_in when flag_we=1 and no pop is active. This gives back-to-back set-flags then conditional execution with no bubble. During an active pop, queries still evaluate against the pre-pop register value.
- Undefined: queries always use the registered flags, as specified above. Adds no logic.

Test Plan:
1. Reset, then flag_we=1, flag_in=4'b0001 (Z=1), mask=4'hF; next cycle query port0 sel=0 (EQ), port1 sel=1 (NE) -> one cycle later cond_pass=2'b01, pass_valid=2'b11, flags_out=4'b0001.
2. Set flags N=1, V=0 (4'b0100); query sel=10 (GE) and sel=11 (LT) -> cond_pass GE=0, LT=1; then set N=1, V=1 (4'b0110) -> GE=1, LT=0, GT=1, LE=0.
3. Flags 4'b1111, then flag_we with flag_in=0, mask=4'b0101 -> flags_out=4'b1010; sel=14 and sel=15 pass regardless of flags.
4. With DEPTH=4: push 4 times with distinct flags 1,2,3,4 -> ckpt_full=1; 5th push -> ckpt_err pulse, count stays 4; pop 4 times -> flags_out 4,3,2,1 in order and ckpt_empty=1; 5th pop -> ckpt_err pulse, flags unchanged.
5. Same-cycle push+flag_we(flag_in=4'hA), then pop+flag_we(flag_in=4'h5) -> after pop flags equal the pre-push value and 4'h5 is ignored; push+pop together -> ckpt_err=1, count unchanged.
6. Assert rst_n=0 asynchronously mid-query with 2 stack entries -> flags_out=RESET_FLAGS, cond_pass=0, ckpt_empty=1 immediately, without waiting for a clock edge. With FLAG_BYPASS_EN defined, flag_we(Z=1) plus sel=0 in the same cycle -> cond_pass=1 next cycle.
